drr_cp_config_master: RTL and testbench



---
 rtl/drr_cp_pkg.sv | 46 ++++
 rtl/cp_timeout_counter.sv | 32 +++
 rtl/drr_cp_config_master.sv | 194 +++++++++++++++++++
 tb/tb_drr_cp_config_master.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drr_cp_pkg.sv
// Shared definitions for the DRR control-plane configuration master:
// widths, response-word field offsets, FSM encoding, error codes and
// the response unpack helper.
package drr_cp_pkg;

   localparam int CP_ID_WIDTH        = 8;
   localparam int CP_ID_LENGHT       = 160;
   localparam int CP_WRITE_WIDTH     = 8;
   localparam int CP_ROUND_WIDTH     = 11;
   localparam int CP_COUNTER_WIDTH   = 17;
   localparam int CP_CPU_OUT_WIDTH   = CP_ROUND_WIDTH + 2 * CP_COUNTER_WIDTH;
   localparam int CP_TIMEOUT_CYCLES  = 16;

   // Field offsets inside cpu_rsp_val: {round, config_weight, weight}
   localparam int RSP_WEIGHT_LSB     = 0;
   localparam int RSP_CFG_LSB        = CP_COUNTER_WIDTH;
   localparam int RSP_ROUND_LSB      = 2 * CP_COUNTER_WIDTH;

   typedef enum logic [1:0] {
      CP_IDLE  = 2'd0,
      CP_ISSUE = 2'd1,
      CP_WAIT  = 2'd2,
      CP_DONE  = 2'd3
   } cp_state_e;

   localparam logic [1:0] ERR_OK       = 2'd0;
   localparam logic [1:0] ERR_RANGE    = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
   localparam logic [1:0] ERR_MISMATCH = 2'd3;

   typedef struct packed {
      logic [CP_ROUND_WIDTH-1:0]   round;
      logic [CP_COUNTER_WIDTH-1:0] cfg_weight;
      logic [CP_COUNTER_WIDTH-1:0] weight;
   } cp_rsp_t;

   // Split a raw responder word into its three fields.
   function automatic cp_rsp_t cp_unpack_rsp(input logic [CP_CPU_OUT_WIDTH-1:0] v);
      cp_rsp_t r;
      r.round      = v[RSP_ROUND_LSB  +: CP_ROUND_WIDTH];
      r.cfg_weight = v[RSP_CFG_LSB    +: CP_COUNTER_WIDTH];
      r.weight     = v[RSP_WEIGHT_LSB +: CP_COUNTER_WIDTH];
      return r;
   endfunction

endpackage

// File: rtl/cp_timeout_counter.sv
// Response timeout counter. Cleared while a transaction is issued,
// counts the cycles spent waiting, saturates at LIMIT-1. expire fires
// on the enabled cycle whose increment reaches LIMIT-1, so the caller
// leaves WAIT exactly LIMIT cycles after the ISSUE cycle.
module cp_timeout_counter #(
   parameter int LIMIT = 16
) (
   input  logic clk_cp,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

   logic [CW-1:0] count;

   // Saturating wait-cycle counter; clear has priority over enable.
   always_ff @(posedge clk_cp or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != CW'(LIMIT - 1))) begin
         count <= count + 1'b1;
      end
   end

   assign expire = enable && (count == CW'(LIMIT - 2));

endmodule

// File: rtl/drr_cp_config_master.sv
// Control-plane initiator for the DRR rank calculator CPU port. Splits a
// host burst (read or write over a contiguous flow-ID range) into single
// transactions, one outstanding at a time, checks each echoed response
// and returns the unpacked fields to the host.
//
// Handshakes:
//   host cmd : a command transfers on a rising clk_cp edge where
//              cmd_valid && cmd_ready; cmd_ready is high only in IDLE and
//              all cmd_* fields are captured on that edge.
//   cpu port : cpu_valid is a one-cycle strobe with no back-pressure; the
//              responder answers once with cpu_rsp_valid and the echoed
//              index, which is only honoured while in WAIT.
//   results  : rd_valid and done are one-cycle pulses with no ready.
module drr_cp_config_master
   import drr_cp_pkg::*;
#(
   parameter int ID_WIDTH        = drr_cp_pkg::CP_ID_WIDTH,
   parameter int ID_LENGHT       = drr_cp_pkg::CP_ID_LENGHT,
   parameter int CPU_WRITE_WIDTH = drr_cp_pkg::CP_WRITE_WIDTH,
   parameter int ROUND_WIDTH     = drr_cp_pkg::CP_ROUND_WIDTH,
   parameter int COUNTER_WIDTH   = drr_cp_pkg::CP_COUNTER_WIDTH,
   parameter int CPU_OUT_WIDTH   = drr_cp_pkg::CP_CPU_OUT_WIDTH,
   parameter int TIMEOUT_CYCLES  = drr_cp_pkg::CP_TIMEOUT_CYCLES
) (
   input  logic                       clk_cp,
   input  logic                       rst,
   // host command
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_write,
   input  logic [ID_WIDTH-1:0]        cmd_base,
   input  logic [ID_WIDTH-1:0]        cmd_count,
   input  logic [CPU_WRITE_WIDTH-1:0] cmd_wdata,
   // rank calculator CPU port
   output logic                       cpu_valid,
   output logic [ID_WIDTH-1:0]        cpu_index,
   output logic                       cpu_write_sig,
   output logic                       cpu_read_sig,
   output logic [CPU_WRITE_WIDTH-1:0] cpu_config_write,
   input  logic                       cpu_rsp_valid,
   input  logic [ID_WIDTH-1:0]        cpu_rsp_index,
   input  logic [CPU_OUT_WIDTH-1:0]   cpu_rsp_val,
   // results to host
   output logic                       rd_valid,
   output logic [ID_WIDTH-1:0]        rd_index,
   output logic [ROUND_WIDTH-1:0]     rd_round,
   output logic [COUNTER_WIDTH-1:0]   rd_cfg_weight,
   output logic [COUNTER_WIDTH-1:0]   rd_weight,
   output logic                       done,
   output logic [1:0]                 err,
   // current FSM state, for observation only
   output cp_state_e                  dbg_state
);

   cp_state_e                  state;
   logic [ID_WIDTH-1:0]        cur_id;
   logic [ID_WIDTH:0]          remaining;
   logic                       is_write;
   logic [CPU_WRITE_WIDTH-1:0] wdata;

   logic [ID_WIDTH:0]          cmd_end;
   logic                       range_bad;
   logic                       rsp_match;
   logic                       tmo_clear;
   logic                       tmo_enable;
   logic                       tmo_expire;
   cp_rsp_t                    rsp;

   // One past the last ID of the burst, computed one bit wider so a base
   // near the top of the ID space cannot wrap past the limit check.
   assign cmd_end   = {1'b0, cmd_base} + {1'b0, cmd_count};
   assign range_bad = (cmd_count == '0) || (cmd_end > (ID_WIDTH + 1)'(ID_LENGHT));
   assign rsp_match = (cpu_rsp_index == cur_id);
   assign rsp       = cp_unpack_rsp(cpu_rsp_val);

   assign cmd_ready = (state == CP_IDLE);
   assign dbg_state = state;

   assign tmo_clear  = (state == CP_ISSUE);
   assign tmo_enable = (state == CP_WAIT);

   cp_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_cp (clk_cp),
      .rst    (rst),
      .clear  (tmo_clear),
      .enable (tmo_enable),
      .expire (tmo_expire)
   );

   // Burst sequencer: state, burst bookkeeping and every registered output.
   always_ff @(posedge clk_cp or negedge rst) begin
      if (!rst) begin
         state            <= CP_IDLE;
         cur_id           <= '0;
         remaining        <= '0;
         is_write         <= 1'b0;
         wdata            <= '0;
         cpu_valid        <= 1'b0;
         cpu_index        <= '0;
         cpu_write_sig    <= 1'b0;
         cpu_read_sig     <= 1'b0;
         cpu_config_write <= '0;
         rd_valid         <= 1'b0;
         rd_index         <= '0;
         rd_round         <= '0;
         rd_cfg_weight    <= '0;
         rd_weight        <= '0;
         done             <= 1'b0;
         err              <= ERR_OK;
      end else begin
         // Strobes and pulses default low; only the transitions below raise them.
         cpu_valid        <= 1'b0;
         cpu_write_sig    <= 1'b0;
         cpu_read_sig     <= 1'b0;
         cpu_config_write <= '0;
         rd_valid         <= 1'b0;
         done             <= 1'b0;
         err              <= ERR_OK;

         case (state)
            CP_IDLE: begin
               if (cmd_valid) begin
                  cur_id    <= cmd_base;
                  remaining <= {1'b0, cmd_count};
                  is_write  <= cmd_write;
                  wdata     <= cmd_wdata;
                  if (range_bad) begin
                     state <= CP_DONE;
                     done  <= 1'b1;
                     err   <= ERR_RANGE;
                  end else begin
                     state            <= CP_ISSUE;
                     cpu_valid        <= 1'b1;
                     cpu_index        <= cmd_base;
                     cpu_write_sig    <= cmd_write;
                     cpu_read_sig     <= !cmd_write;
                     cpu_config_write <= cmd_write ? cmd_wdata : '0;
                  end
               end
            end

            CP_ISSUE: begin
               state <= CP_WAIT;
            end

            CP_WAIT: begin
               // A response beats the timeout when both land together.
               if (cpu_rsp_valid) begin
                  if (rsp_match) begin
                     rd_valid      <= 1'b1;
                     rd_index      <= cur_id;
                     rd_round      <= rsp.round;
                     rd_cfg_weight <= rsp.cfg_weight;
                     rd_weight     <= rsp.weight;
                     cur_id        <= cur_id + 1'b1;
                     remaining     <= remaining - 1'b1;
                     if (remaining == (ID_WIDTH + 1)'(1)) begin
                        state <= CP_DONE;
                        done  <= 1'b1;
                        err   <= ERR_OK;
                     end else begin
                        state            <= CP_ISSUE;
                        cpu_valid        <= 1'b1;
                        cpu_index        <= cur_id + 1'b1;
                        cpu_write_sig    <= is_write;
                        cpu_read_sig     <= !is_write;
                        cpu_config_write <= is_write ? wdata : '0;
                     end
                  end else begin
                     state <= CP_DONE;
                     done  <= 1'b1;
                     err   <= ERR_MISMATCH;
                  end
               end else if (tmo_expire) begin
                  state <= CP_DONE;
                  done  <= 1'b1;
                  err   <= ERR_TIMEOUT;
               end
            end

            CP_DONE: begin
               state <= CP_IDLE;
            end

            default: begin
               state <= CP_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_drr_cp_config_master.sv
// Bench for drr_cp_config_master: a table of directed bursts with
// hand-computed outcomes, a 1-cycle responder standing in for the rank
// calculator, and hand-written sequences for stray responses and a
// mid-burst reset.
module tb_drr_cp_config_master;
   import drr_cp_pkg::*;

   localparam int TIMEOUT    = 16;
   localparam int M_NORM     = 0;
   localparam int M_MISMATCH = 1;
   localparam int M_SILENT   = 2;
   localparam int NVEC       = 14;

   typedef struct {
      logic       wr;
      logic [7:0] base;
      logic [7:0] count;
      logic [7:0] wdata;
      int         mode;
      logic [1:0] err;
      int         n_txn;
      int         n_rd;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic        clk_cp;
   logic        rst;

   initial begin
      clk_cp = 1'b0;
      forever #5 clk_cp = ~clk_cp;
   end

   int cyc = 0;
   always @(posedge clk_cp) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [7:0]  cmd_base, cmd_count, cmd_wdata;
   logic        cpu_valid, cpu_write_sig, cpu_read_sig;
   logic [7:0]  cpu_index, cpu_config_write;
   logic        cpu_rsp_valid;
   logic [7:0]  cpu_rsp_index;
   logic [44:0] cpu_rsp_val;
   logic        rd_valid;
   logic [7:0]  rd_index;
   logic [10:0] rd_round;
   logic [16:0] rd_cfg_weight, rd_weight;
   logic        done;
   logic [1:0]  err;
   cp_state_e   dbg_state;

   drr_cp_config_master dut (
      .clk_cp           (clk_cp),
      .rst              (rst),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_write        (cmd_write),
      .cmd_base         (cmd_base),
      .cmd_count        (cmd_count),
      .cmd_wdata        (cmd_wdata),
      .cpu_valid        (cpu_valid),
      .cpu_index        (cpu_index),
      .cpu_write_sig    (cpu_write_sig),
      .cpu_read_sig     (cpu_read_sig),
      .cpu_config_write (cpu_config_write),
      .cpu_rsp_valid    (cpu_rsp_valid),
      .cpu_rsp_index    (cpu_rsp_index),
      .cpu_rsp_val      (cpu_rsp_val),
      .rd_valid         (rd_valid),
      .rd_index         (rd_index),
      .rd_round         (rd_round),
      .rd_cfg_weight    (rd_cfg_weight),
      .rd_weight        (rd_weight),
      .done             (done),
      .err              (err),
      .dbg_state        (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  rd_idx_q[$];
   logic [16:0] cfg_q[$];
   logic [16:0] cfg_model[256];
   logic [16:0] mem[256];
   vec_t        vecs[NVEC];

   int          mode = M_NORM;
   logic        stray_req = 1'b0;
   logic        pend = 1'b0;
   logic [7:0]  pend_idx;
   logic [16:0] pend_cfg;
   logic        cur_write = 1'b0;
   logic [7:0]  cur_wdata = 8'd0;
   int          n_txn, n_rd, n_done;
   int          acc_cyc, first_issue_cyc, last_issue_cyc, last_rd_cyc, done_cyc;
   logic [1:0]  done_err;
   logic        ready_pending = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- responder: registered, one cycle ----------------
   // Returns {round=5, cfg=mem[id], weight=100}; writes report the pre-write
   // config weight and then update mem.
   always @(negedge clk_cp) begin
      if (!rst) begin
         pend          = 1'b0;
         cpu_rsp_valid = 1'b0;
      end else begin
         if (pend && mode != M_SILENT) begin
            cpu_rsp_valid = 1'b1;
            cpu_rsp_index = (mode == M_MISMATCH) ? pend_idx + 8'd1 : pend_idx;
            cpu_rsp_val   = {11'd5, pend_cfg, 17'd100};
         end else if (stray_req) begin
            cpu_rsp_valid = 1'b1;
            cpu_rsp_index = 8'h23;
            cpu_rsp_val   = {11'd9, 17'd9, 17'd9};
            stray_req     = 1'b0;
         end else begin
            cpu_rsp_valid = 1'b0;
         end
         pend = cpu_valid;
         if (cpu_valid) begin
            pend_idx = cpu_index;
            pend_cfg = mem[cpu_index];
            if (cpu_write_sig) mem[cpu_index] = {9'd0, cpu_config_write};
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk_cp) begin
      if (rst) begin
         if (ready_pending) begin
            chk("cmd_ready_after_done", 64'(cmd_ready), 64'(1));
            ready_pending = 1'b0;
         end
         chk("strobe_outside_issue", 64'((cpu_write_sig | cpu_read_sig) & !cpu_valid), 64'(0));
         if (cpu_valid) begin
            chk("issue_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) chk("cpu_index", 64'(cpu_index), 64'(exp_q.pop_front()));
            chk("cpu_write_sig", 64'(cpu_write_sig), 64'(cur_write));
            chk("cpu_read_sig", 64'(cpu_read_sig), 64'(!cur_write));
            chk("cpu_config_write", 64'(cpu_config_write), 64'(cur_write ? cur_wdata : 8'd0));
            chk("cmd_ready_busy", 64'(cmd_ready), 64'(0));
            if (n_txn == 0) first_issue_cyc = cyc;
            else chk("issue_spacing", 64'(cyc - last_issue_cyc), 64'(2));
            last_issue_cyc = cyc;
            n_txn++;
         end
         if (rd_valid) begin
            chk("rd_expected", 64'(rd_idx_q.size() != 0), 64'(1));
            if (rd_idx_q.size() != 0) begin
               chk("rd_index", 64'(rd_index), 64'(rd_idx_q.pop_front()));
               chk("rd_cfg_weight", 64'(rd_cfg_weight), 64'(cfg_q.pop_front()));
            end
            chk("rd_round", 64'(rd_round), 64'(5));
            chk("rd_weight", 64'(rd_weight), 64'(100));
            last_rd_cyc = cyc;
            n_rd++;
         end
         if (done) begin
            n_done++;
            done_cyc      = cyc;
            done_err      = err;
            ready_pending = 1'b1;
         end
      end else begin
         ready_pending = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic prep_vec(input vec_t v);
      exp_q.delete();
      rd_idx_q.delete();
      cfg_q.delete();
      for (int i = 0; i < v.n_txn; i++) exp_q.push_back(8'(v.base + i));
      for (int i = 0; i < v.n_rd; i++) begin
         rd_idx_q.push_back(8'(v.base + i));
         cfg_q.push_back(cfg_model[8'(v.base + i)]);
      end
      if (v.wr && v.err == ERR_OK)
         for (int i = 0; i < int'(v.count); i++) cfg_model[8'(v.base + i)] = {9'd0, v.wdata};
      mode      = v.mode;
      cur_write = v.wr;
      cur_wdata = v.wdata;
      n_txn     = 0;
      n_rd      = 0;
      n_done    = 0;
   endtask

   // Presents the command for one cycle, then scrambles the fields so any
   // failure to latch them at acceptance shows up.
   task automatic issue_cmd(input vec_t v, input string tag);
      int k;
      k = 0;
      while (!cmd_ready && k < 50) begin
         @(negedge clk_cp);
         k++;
      end
      chk({tag, "_ready_wait"}, 64'(cmd_ready), 64'(1));
      cmd_valid = 1'b1;
      cmd_write = v.wr;
      cmd_base  = v.base;
      cmd_count = v.count;
      cmd_wdata = v.wdata;
      acc_cyc   = cyc;
      @(negedge clk_cp);
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom_range(0, 1));
      cmd_base  = 8'($urandom_range(0, 255));
      cmd_count = 8'($urandom_range(0, 255));
      cmd_wdata = 8'($urandom_range(0, 255));
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int k;
      prep_vec(v);
      issue_cmd(v, tag);
      k = 0;
      while (n_done == 0 && k < 2 * int'(v.count) + 40) begin
         @(negedge clk_cp);
         k++;
      end
      @(negedge clk_cp);
      chk({tag, "_done_count"}, 64'(n_done), 64'(1));
      chk({tag, "_err"}, 64'(done_err), 64'(v.err));
      chk({tag, "_txn_count"}, 64'(n_txn), 64'(v.n_txn));
      chk({tag, "_rd_count"}, 64'(n_rd), 64'(v.n_rd));
      if (v.n_txn > 0) chk({tag, "_first_issue_lat"}, 64'(first_issue_cyc - acc_cyc), 64'(1));
      case (v.err)
         ERR_RANGE:    chk({tag, "_done_lat"}, 64'(done_cyc - acc_cyc), 64'(1));
         ERR_OK:       chk({tag, "_done_vs_rd"}, 64'(done_cyc - last_rd_cyc), 64'(0));
         ERR_TIMEOUT:  chk({tag, "_timeout_lat"}, 64'(done_cyc - first_issue_cyc), 64'(TIMEOUT));
         default:      chk({tag, "_mismatch_lat"}, 64'(done_cyc - first_issue_cyc), 64'(2));
      endcase
      mode = M_NORM;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int   k;
      vec_t v;

      for (int i = 0; i < 256; i++) begin
         mem[i]       = 17'd2;
         cfg_model[i] = 17'd2;
      end

      //                wr    base    count   wdata  mode        err           txn  rd
      vecs[0]  = '{1'b0, 8'h23, 8'd3,   8'd0,  M_NORM,     ERR_OK,       3,   3};
      vecs[1]  = '{1'b1, 8'd0,  8'd1,   8'd4,  M_NORM,     ERR_OK,       1,   1};
      vecs[2]  = '{1'b0, 8'd0,  8'd1,   8'd0,  M_NORM,     ERR_OK,       1,   1};
      vecs[3]  = '{1'b0, 8'd158,8'd3,   8'd0,  M_NORM,     ERR_RANGE,    0,   0};
      vecs[4]  = '{1'b0, 8'd10, 8'd0,   8'd0,  M_NORM,     ERR_RANGE,    0,   0};
      vecs[5]  = '{1'b0, 8'd157,8'd3,   8'd0,  M_NORM,     ERR_OK,       3,   3};
      vecs[6]  = '{1'b1, 8'd157,8'd3,   8'd7,  M_NORM,     ERR_OK,       3,   3};
      vecs[7]  = '{1'b0, 8'd157,8'd3,   8'd0,  M_NORM,     ERR_OK,       3,   3};
      vecs[8]  = '{1'b0, 8'd50, 8'd2,   8'd0,  M_MISMATCH, ERR_MISMATCH, 1,   0};
      vecs[9]  = '{1'b0, 8'd60, 8'd1,   8'd0,  M_SILENT,   ERR_TIMEOUT,  1,   0};
      vecs[10] = '{1'b1, 8'd255,8'd1,   8'd9,  M_NORM,     ERR_RANGE,    0,   0};
      vecs[11] = '{1'b0, 8'd159,8'd1,   8'd0,  M_NORM,     ERR_OK,       1,   1};
      vecs[12] = '{1'b0, 8'd1,  8'd160, 8'd0,  M_NORM,     ERR_RANGE,    0,   0};
      vecs[13] = '{1'b0, 8'd0,  8'd160, 8'd0,  M_NORM,     ERR_OK,       160, 160};

      rst       = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_base  = 8'd0;
      cmd_count = 8'd0;
      cmd_wdata = 8'd0;
      cpu_rsp_valid = 1'b0;
      cpu_rsp_index = 8'd0;
      cpu_rsp_val   = '0;

      repeat (3) @(negedge clk_cp);
      chk("reset_cpu_valid_in_rst", 64'(cpu_valid), 64'(0));
      rst = 1'b1;
      @(negedge clk_cp);
      chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("reset_state", 64'(dbg_state), 64'(CP_IDLE));
      chk("reset_outputs", 64'({cpu_valid, cpu_write_sig, cpu_read_sig, rd_valid, done}), 64'(0));
      chk("reset_err", 64'(err), 64'(0));
      chk("reset_cpu_index", 64'(cpu_index), 64'(0));
      chk("reset_rd_fields", 64'({rd_index, rd_round, rd_cfg_weight, rd_weight}), 64'(0));

      for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Stray response while idle: must be ignored entirely.
      prep_vec('{1'b0, 8'd0, 8'd0, 8'd0, M_NORM, ERR_OK, 0, 0});
      stray_req = 1'b1;
      repeat (5) @(negedge clk_cp);
      chk("stray_consumed", 64'(stray_req), 64'(0));
      chk("stray_no_rd", 64'(n_rd), 64'(0));
      chk("stray_no_done", 64'(n_done), 64'(0));
      chk("stray_state", 64'(dbg_state), 64'(CP_IDLE));

      // Reset in the middle of a 5-ID read burst.
      v = '{1'b0, 8'd20, 8'd5, 8'd0, M_NORM, ERR_OK, 5, 5};
      prep_vec(v);
      issue_cmd(v, "rstmid");
      k = 0;
      while (!(n_rd >= 2 && cpu_valid) && k < 100) begin
         @(negedge clk_cp);
         k++;
      end
      chk("rstmid_reached_issue", 64'(cpu_valid), 64'(1));
      n_done = 0;
      rst = 1'b0;
      #1;
      chk("rstmid_cpu_valid_drop", 64'(cpu_valid), 64'(0));
      chk("rstmid_read_sig_drop", 64'(cpu_read_sig), 64'(0));
      repeat (3) @(negedge clk_cp);
      chk("rstmid_done_in_rst", 64'(done), 64'(0));
      rst = 1'b1;
      repeat (6) @(negedge clk_cp);
      chk("rstmid_no_done", 64'(n_done), 64'(0));
      chk("rstmid_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("rstmid_state", 64'(dbg_state), 64'(CP_IDLE));
      run_vec('{1'b0, 8'd20, 8'd5, 8'd0, M_NORM, ERR_OK, 5, 5}, "after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
